// File: rtl/accum_capture_sequencer.sv
// accum_capture_sequencer
// Sequences one averaging run of NUM_AVG triggered events for the data
// accumulator: clears it, arms a rising-crossing threshold trigger on the raw
// ADC stream, strobes one capture per event, holds off re-triggering while a
// record is processed, and waits for the output FIFO to drain at the end.

module accum_capture_sequencer #(
    parameter int RECORD_LEN = 128,
    parameter int HOLDOFF    = 8,
    parameter int NUM_AVG    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic signed [7:0] inputData,
    input  logic signed [7:0] threshold,
    input  logic              forceTrig,
    input  logic              dataEmpty,
    output logic              dataCaptureStrobe,
    output logic              accumRst,
    output logic              busy,
    output logic              runDone,
    output logic [7:0]        eventCount,
    output logic              triggerLost
);

    // Dead window after a strobe: record processing plus holdoff.
    localparam int               WINDOW   = RECORD_LEN + HOLDOFF;
    localparam int               WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW - 1);
    localparam logic [7:0]       AVG_LAST = 8'(NUM_AVG);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ARMED,
        CAPTURE,
        DRAIN,
        CLEAR_ABORT
    } state_t;

    state_t            state;
    logic signed [7:0] s0;
    logic signed [7:0] s1;
    logic [WIN_W-1:0]  win_cnt;
    logic              clr_phase;
    logic              empty_seen;
    logic              trig;
    logic              abort_go;
    logic [7:0]        next_count;

    // Both operands are signed, so this is a two's-complement compare; the
    // pair (s0 below, s1 at/above) only matches on a rising crossing.
    assign trig       = ((s0 < threshold) && (s1 >= threshold)) || forceTrig;
    assign abort_go   = abort && (state != IDLE) && (state != CLEAR_ABORT);
    assign next_count = eventCount + 8'd1;
    assign busy       = (state != IDLE);

    // Two-stage sample delay; together with the registered strobe this gives
    // the fixed 2-cycle crossing-to-strobe latency the accumulator expects.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s0 <= '0;
        end else begin
            s1 <= inputData;
            s0 <= s1;
        end
    end

    // Run sequencer: state, counters and all registered outputs.
    // NOTE: reset is synchronous and shared with the accumulator, so it is
    // tested first inside the clocked block and overrides abort and start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            dataCaptureStrobe <= 1'b0;
            accumRst          <= 1'b0;
            runDone           <= 1'b0;
            eventCount        <= '0;
            triggerLost       <= 1'b0;
            win_cnt           <= '0;
            clr_phase         <= 1'b0;
            empty_seen        <= 1'b0;
        end else begin
            dataCaptureStrobe <= 1'b0;
            runDone           <= 1'b0;

            if (abort_go) begin
                state     <= CLEAR_ABORT;
                accumRst  <= 1'b1;
                clr_phase <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state       <= CLEAR;
                            accumRst    <= 1'b1;
                            clr_phase   <= 1'b0;
                            eventCount  <= '0;
                            triggerLost <= 1'b0;
                        end
                    end

                    CLEAR: begin
                        if (clr_phase) begin
                            state    <= ARMED;
                            accumRst <= 1'b0;
                        end else begin
                            clr_phase <= 1'b1;
                        end
                    end

                    ARMED: begin
                        if (trig) begin
                            state             <= CAPTURE;
                            dataCaptureStrobe <= 1'b1;
                            win_cnt           <= WIN_LOAD;
                        end
                    end

                    CAPTURE: begin
                        // A trigger during the dead window is dropped but
                        // remembered, including on the final window cycle.
                        if (trig) begin
                            triggerLost <= 1'b1;
                        end
                        if (win_cnt == '0) begin
                            eventCount <= next_count;
                            empty_seen <= 1'b0;
                            state      <= (next_count == AVG_LAST) ? DRAIN : ARMED;
                        end else begin
                            win_cnt <= win_cnt - 1'b1;
                        end
                    end

                    DRAIN: begin
                        if (dataEmpty) begin
                            if (empty_seen) begin
                                runDone <= 1'b1;
                                state   <= IDLE;
                            end else begin
                                empty_seen <= 1'b1;
                            end
                        end else begin
                            empty_seen <= 1'b0;
                        end
                    end

                    CLEAR_ABORT: begin
                        if (clr_phase) begin
                            state    <= IDLE;
                            accumRst <= 1'b0;
                        end else begin
                            clr_phase <= 1'b1;
                        end
                    end

                    default: begin
                        state    <= IDLE;
                        accumRst <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/accum_capture_sequencer.md
# accum_capture_sequencer

Controller that sequences the averaging data accumulator over one run of NUM_AVG triggered events. On start it clears the accumulator, arms a threshold trigger on the raw 8-bit ADC stream, issues one capture strobe per event, and holds off re-triggering while the accumulator processes the record. After the last event it waits for the accumulator's output FIFO to drain. It sits between the software command interface and the accumulator's `dataCaptureStrobe`/`rst` inputs.

## Interface
- RECORD_LEN, 128: accumulator busy cycles per event, measured from strobe.
- HOLDOFF, 8: extra dead cycles after RECORD_LEN before re-arming.
- NUM_AVG, 4: events per run; range 1..255.
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle pulse that begins a run; ignored unless IDLE.
- abort  in  1  one-cycle pulse that terminates a run from any non-IDLE state.
- inputData  in  8  signed ADC sample, one per clk.
- threshold  in  8  signed trigger level; sampled every cycle.
- forceTrig  in  1  software trigger, valid only in ARMED.
- dataEmpty  in  1  accumulator output-FIFO empty flag.
- dataCaptureStrobe  out  1  one-cycle capture pulse to the accumulator.
- accumRst  out  1  reset to the accumulator.
- busy  out  1  high in every state except IDLE.
- runDone  out  1  one-cycle pulse when a run completes normally.
- eventCount  out  8  number of events completed in the current run.
- triggerLost  out  1  sticky flag; a trigger arrived in CAPTURE.

## Operation
- Reset: state IDLE. All outputs are 0, and so are the internal counters and sample registers.
- Sample pipeline: s1 <= inputData and s0 <= s1 every cycle.
- Trigger condition: trig = ((s0 < threshold) && (s1 >= threshold)) || forceTrig. This is a signed compare and fires on the rising crossing only.
- IDLE: start moves to CLEAR. Entering CLEAR zeroes eventCount and clears triggerLost.
- CLEAR: accumRst is high for exactly 2 cycles, then the state moves to ARMED.
- ARMED: trig moves to CAPTURE. The window counter is loaded with RECORD_LEN+HOLDOFF-1.
- CAPTURE: the counter decrements every cycle. At 0, eventCount increments.
  - If the new eventCount equals NUM_AVG, go to DRAIN.
  - Otherwise go to ARMED.
- CAPTURE trigger handling: a trig here sets triggerLost and produces no strobe.
- DRAIN: the state waits for dataEmpty=1 on 2 consecutive cycles. It then pulses runDone and goes to IDLE.
- abort: takes priority over every other transition in CLEAR, ARMED, CAPTURE and DRAIN.
  - The next state is CLEAR_ABORT: accumRst is high for 2 cycles, then IDLE. No runDone pulse.
  - eventCount and triggerLost hold their values until the next start.
- Simultaneous inputs:
  - start in IDLE together with abort: start wins.
  - trig on the same cycle as the CAPTURE counter reaching 0: the trig is lost (triggerLost=1). Re-arming takes 1 cycle.
- eventCount never wraps. Because NUM_AVG is at most 255, the run ends first.
- Outputs are registered except busy, which is decoded from state.

## Timing
- start sampled high at cycle t: accumRst is high at t+1 and t+2. ARMED is active at t+3.
- Trigger latency: a sample crossing the threshold arrives on inputData at cycle t. trig is seen at t+1 and dataCaptureStrobe is high at t+2.
  - The total of 2 cycles is fixed. It matches the accumulator's one-cycle offset register.
- The strobe is high for exactly 1 cycle.
- Minimum spacing between strobes is RECORD_LEN+HOLDOFF+1 cycles.
- eventCount updates on the cycle after the last CAPTURE cycle.
- Drain timing: runDone is high exactly 1 cycle, on the cycle after the second consecutive dataEmpty=1 in DRAIN.
- Reset mid-run: rst wins over abort and start. The block returns to IDLE in 1 cycle with accumRst=0. The accumulator is expected to share rst.

## Test plan
- Reset with all inputs 0: every output is 0 and busy=0.
- Basic run, NUM_AVG=4: drive start, then a ramp -10..+10 against threshold=0.
  - Expect 4 strobes, each exactly 2 cycles after the crossing sample.
  - Strobes are at least 137 cycles apart. eventCount steps 1..4.
  - runDone pulses once, 2 cycles after dataEmpty goes high.
- Holdoff: inject a second crossing 50 cycles after a strobe.
  - No strobe. triggerLost=1, and it stays set until the next start.
- Abort in CAPTURE with eventCount=2: accumRst is high for 2 cycles, then IDLE.
  - eventCount holds at 2. No runDone.
- forceTrig in ARMED with a flat input of 5 and threshold=0: a strobe 1 cycle after forceTrig.
  - forceTrig in IDLE: no effect.
- start and abort asserted together in IDLE: the run starts. rst asserted mid-DRAIN: IDLE on the next cycle and runDone stays 0.
